// File: rtl/hex_pixel_fetch.sv
// hex_pixel_fetch: gathers the 7 current-frame and 7 reference-frame hexagon
// pixels for one search step from two synchronous single-port frame memories.
module hex_pixel_fetch #(
  parameter int FRAME_W      = 96,
  parameter int FRAME_H      = 96,
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [48:0]       cf_x_bus,
  input  logic [48:0]       cf_y_bus,
  input  logic [48:0]       rf_x_bus,
  input  logic [48:0]       rf_y_bus,
  output logic              cf_mem_en,
  output logic [ADDR_W-1:0] cf_mem_addr,
  input  logic [7:0]        cf_mem_rdata,
  output logic              rf_mem_en,
  output logic [ADDR_W-1:0] rf_mem_addr,
  input  logic [7:0]        rf_mem_rdata,
  output logic [55:0]       cf_pix_bus,
  output logic [55:0]       rf_pix_bus,
  output logic [6:0]        cf_oob,
  output logic [6:0]        rf_oob,
  output logic              busy,
  output logic              done
);

  localparam int         NSLOT      = 7;
  localparam logic [2:0] LAST_SLOT  = 3'd6;
  localparam logic [1:0] LAST_DRAIN = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [1:0] drain_q, drain_d;
  logic       latch;

  logic [6:0] cf_x_q [NSLOT];
  logic [6:0] cf_y_q [NSLOT];
  logic [6:0] rf_x_q [NSLOT];
  logic [6:0] rf_y_q [NSLOT];
  logic [6:0] cf_x_d [NSLOT];
  logic [6:0] cf_y_d [NSLOT];
  logic [6:0] rf_x_d [NSLOT];
  logic [6:0] rf_y_d [NSLOT];

  logic [7:0] cf_stg_q [NSLOT];
  logic [7:0] rf_stg_q [NSLOT];
  logic [7:0] cf_stg_d [NSLOT];
  logic [7:0] rf_stg_d [NSLOT];
  logic [6:0] cf_stg_oob_q, cf_stg_oob_d;
  logic [6:0] rf_stg_oob_q, rf_stg_oob_d;

  logic [7:0] cf_pix_q [NSLOT];
  logic [7:0] rf_pix_q [NSLOT];
  logic [7:0] cf_pix_d [NSLOT];
  logic [7:0] rf_pix_d [NSLOT];
  logic [6:0] cf_oob_q, cf_oob_d;
  logic [6:0] rf_oob_q, rf_oob_d;

  logic [READ_LATENCY-1:0] cf_pv_q, cf_pv_d;
  logic [READ_LATENCY-1:0] rf_pv_q, rf_pv_d;
  logic [2:0]              ps_q [READ_LATENCY];
  logic [2:0]              ps_d [READ_LATENCY];

  logic [6:0]        cur_cf_x, cur_cf_y, cur_rf_x, cur_rf_y;
  logic              cf_in, rf_in;
  logic [ADDR_W-1:0] cf_lin, rf_lin;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    drain_d = drain_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          latch   = 1'b1;
          state_d = ST_ISSUE;
          slot_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (slot_q == LAST_SLOT) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (req) begin
          latch   = 1'b1;
          state_d = ST_ISSUE;
          slot_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      cf_x_d[s] = latch ? cf_x_bus[7*s +: 7] : cf_x_q[s];
      cf_y_d[s] = latch ? cf_y_bus[7*s +: 7] : cf_y_q[s];
      rf_x_d[s] = latch ? rf_x_bus[7*s +: 7] : rf_x_q[s];
      rf_y_d[s] = latch ? rf_y_bus[7*s +: 7] : rf_y_q[s];
    end
  end

  // In-frame addresses fit ADDR_W exactly, so the product is formed at that width.
  always_comb begin
    cur_cf_x = cf_x_q[slot_q];
    cur_cf_y = cf_y_q[slot_q];
    cur_rf_x = rf_x_q[slot_q];
    cur_rf_y = rf_y_q[slot_q];
    cf_in = (state_q == ST_ISSUE) && (32'(cur_cf_x) < FRAME_H) && (32'(cur_cf_y) < FRAME_W);
    rf_in = (state_q == ST_ISSUE) && (32'(cur_rf_x) < FRAME_H) && (32'(cur_rf_y) < FRAME_W);
    cf_lin = ADDR_W'(cur_cf_x) * ADDR_W'(FRAME_W) + ADDR_W'(cur_cf_y);
    rf_lin = ADDR_W'(cur_rf_x) * ADDR_W'(FRAME_W) + ADDR_W'(cur_rf_y);
    cf_mem_en   = cf_in;
    rf_mem_en   = rf_in;
    cf_mem_addr = cf_in ? cf_lin : '0;
    rf_mem_addr = rf_in ? rf_lin : '0;
  end

  always_comb begin
    cf_pv_d[0] = cf_in;
    rf_pv_d[0] = rf_in;
    ps_d[0]    = slot_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      cf_pv_d[i] = cf_pv_q[i-1];
      rf_pv_d[i] = rf_pv_q[i-1];
      ps_d[i]    = ps_q[i-1];
    end
  end

  // Out-of-frame slots are resolved at issue; in-frame slots fill when their read returns.
  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      cf_stg_d[s] = cf_stg_q[s];
      rf_stg_d[s] = rf_stg_q[s];
    end
    cf_stg_oob_d = cf_stg_oob_q;
    rf_stg_oob_d = rf_stg_oob_q;
    if (state_q == ST_ISSUE) begin
      cf_stg_oob_d[slot_q] = ~cf_in;
      rf_stg_oob_d[slot_q] = ~rf_in;
      if (!cf_in) cf_stg_d[slot_q] = '0;
      if (!rf_in) rf_stg_d[slot_q] = '0;
    end
    if (cf_pv_q[READ_LATENCY-1]) cf_stg_d[ps_q[READ_LATENCY-1]] = cf_mem_rdata;
    if (rf_pv_q[READ_LATENCY-1]) rf_stg_d[ps_q[READ_LATENCY-1]] = rf_mem_rdata;
  end

  // The last read lands on the same edge that enters DONE, so publish the next staging value.
  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      cf_pix_d[s] = cf_pix_q[s];
      rf_pix_d[s] = rf_pix_q[s];
    end
    cf_oob_d = cf_oob_q;
    rf_oob_d = rf_oob_q;
    if (state_q == ST_DRAIN && state_d == ST_DONE) begin
      for (int s = 0; s < NSLOT; s++) begin
        cf_pix_d[s] = cf_stg_d[s];
        rf_pix_d[s] = rf_stg_d[s];
      end
      cf_oob_d = cf_stg_oob_d;
      rf_oob_d = rf_stg_oob_d;
    end
  end

  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      cf_pix_bus[8*s +: 8] = cf_pix_q[s];
      rf_pix_bus[8*s +: 8] = rf_pix_q[s];
    end
    cf_oob = cf_oob_q;
    rf_oob = rf_oob_q;
    busy   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    done   = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      drain_q      <= '0;
      cf_x_q       <= '{default: '0};
      cf_y_q       <= '{default: '0};
      rf_x_q       <= '{default: '0};
      rf_y_q       <= '{default: '0};
      cf_stg_q     <= '{default: '0};
      rf_stg_q     <= '{default: '0};
      cf_stg_oob_q <= '0;
      rf_stg_oob_q <= '0;
      cf_pix_q     <= '{default: '0};
      rf_pix_q     <= '{default: '0};
      cf_oob_q     <= '0;
      rf_oob_q     <= '0;
      cf_pv_q      <= '0;
      rf_pv_q      <= '0;
      ps_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      drain_q      <= drain_d;
      cf_x_q       <= cf_x_d;
      cf_y_q       <= cf_y_d;
      rf_x_q       <= rf_x_d;
      rf_y_q       <= rf_y_d;
      cf_stg_q     <= cf_stg_d;
      rf_stg_q     <= rf_stg_d;
      cf_stg_oob_q <= cf_stg_oob_d;
      rf_stg_oob_q <= rf_stg_oob_d;
      cf_pix_q     <= cf_pix_d;
      rf_pix_q     <= rf_pix_d;
      cf_oob_q     <= cf_oob_d;
      rf_oob_q     <= rf_oob_d;
      cf_pv_q      <= cf_pv_d;
      rf_pv_q      <= rf_pv_d;
      ps_q         <= ps_d;
    end
  end

endmodule

// File: tb/tb_hex_pixel_fetch.sv
// Bench for hex_pixel_fetch: a read-latency-1 and a read-latency-3 instance share
// stimulus and are compared against a coordinate-level reference model.
module tb_hex_pixel_fetch;

  localparam int FW = 96;
  localparam int FH = 96;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [48:0] cfX, cfY, rfX, rfY;

  logic        cf1En, rf1En, cf3En, rf3En;
  logic [13:0] cf1Addr, rf1Addr, cf3Addr, rf3Addr;
  logic [7:0]  cf1Rdata, rf1Rdata, cf3Rdata, rf3Rdata;
  logic [7:0]  cf3P0, cf3P1, rf3P0, rf3P1;
  logic [55:0] cf1Pix, rf1Pix, cf3Pix, rf3Pix;
  logic [6:0]  cf1Oob, rf1Oob, cf3Oob, rf3Oob;
  logic        busy1, done1, busy3, done3;

  int          nChecks = 0;
  int          nErrors = 0;
  logic [125:0] held1, held3;

  always #5 clk = ~clk;

  hex_pixel_fetch #(.FRAME_W(FW), .FRAME_H(FH), .ADDR_W(14), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .cf_x_bus(cfX), .cf_y_bus(cfY), .rf_x_bus(rfX), .rf_y_bus(rfY),
    .cf_mem_en(cf1En), .cf_mem_addr(cf1Addr), .cf_mem_rdata(cf1Rdata),
    .rf_mem_en(rf1En), .rf_mem_addr(rf1Addr), .rf_mem_rdata(rf1Rdata),
    .cf_pix_bus(cf1Pix), .rf_pix_bus(rf1Pix), .cf_oob(cf1Oob), .rf_oob(rf1Oob),
    .busy(busy1), .done(done1)
  );

  hex_pixel_fetch #(.FRAME_W(FW), .FRAME_H(FH), .ADDR_W(14), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req(req),
    .cf_x_bus(cfX), .cf_y_bus(cfY), .rf_x_bus(rfX), .rf_y_bus(rfY),
    .cf_mem_en(cf3En), .cf_mem_addr(cf3Addr), .cf_mem_rdata(cf3Rdata),
    .rf_mem_en(rf3En), .rf_mem_addr(rf3Addr), .rf_mem_rdata(rf3Rdata),
    .cf_pix_bus(cf3Pix), .rf_pix_bus(rf3Pix), .cf_oob(cf3Oob), .rf_oob(rf3Oob),
    .busy(busy3), .done(done3)
  );

  // Frame memories: cf[a] = a mod 256, rf[a] = (a+3) mod 256; junk when not enabled.
  always @(posedge clk) begin
    cf1Rdata <= cf1En ? cf1Addr[7:0] : 8'hA5;
    rf1Rdata <= rf1En ? rf1Addr[7:0] + 8'd3 : 8'h5A;
    cf3P0    <= cf3En ? cf3Addr[7:0] : 8'hA5;
    rf3P0    <= rf3En ? rf3Addr[7:0] + 8'd3 : 8'h5A;
    cf3P1    <= cf3P0;
    rf3P1    <= rf3P0;
    cf3Rdata <= cf3P1;
    rf3Rdata <= rf3P1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: per slot, oob if outside the frame, else the memory byte at x*FW+y.
  function automatic logic [62:0] frameRef(input logic [48:0] xb, input logic [48:0] yb, input int off);
    logic [55:0] pix;
    logic [6:0]  oob;
    int x, y;
    pix = '0;
    oob = '0;
    for (int s = 0; s < 7; s++) begin
      x = int'(xb[7*s +: 7]);
      y = int'(yb[7*s +: 7]);
      if (x >= FH || y >= FW) oob[s] = 1'b1;
      else pix[8*s +: 8] = 8'((x * FW + y + off) % 256);
    end
    return {oob, pix};
  endfunction

  function automatic logic [125:0] fullRef(input logic [48:0] ax, input logic [48:0] ay,
                                            input logic [48:0] bx, input logic [48:0] by);
    logic [62:0] c, r;
    c = frameRef(ax, ay, 0);
    r = frameRef(bx, by, 3);
    return {c[62:56], r[62:56], c[55:0], r[55:0]};
  endfunction

  function automatic logic [14:0] issueRef(input logic [48:0] xb, input logic [48:0] yb, input int s);
    int x, y;
    x = int'(xb[7*s +: 7]);
    y = int'(yb[7*s +: 7]);
    if (x >= FH || y >= FW) return 15'd0;
    return {1'b1, 14'(x * FW + y)};
  endfunction

  function automatic logic [48:0] randBus();
    logic [48:0] b;
    for (int s = 0; s < 7; s++)
      b[7*s +: 7] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 95));
    return b;
  endfunction

  function automatic logic [48:0] noiseBus();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[48:0];
  endfunction

  // Fetch A with req in cycle 0 (called at a negedge); optional extra req noise in
  // cycles 2..8 and an optional back-to-back fetch B requested in cycle 9.
  task automatic applyStimulus(input logic [48:0] aCx, input logic [48:0] aCy,
                               input logic [48:0] aRx, input logic [48:0] aRy,
                               input logic [48:0] bCx, input logic [48:0] bCy,
                               input logic [48:0] bRx, input logic [48:0] bRy,
                               input bit noisy, input bit b2b);
    logic [14:0] e1c, e1r, e3c, e3r;
    cfX = aCx; cfY = aCy; rfX = aRx; rfY = aRy;
    req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      e1c = '0; e1r = '0; e3c = '0; e3r = '0;
      if (k <= 7) begin
        e1c = issueRef(aCx, aCy, k - 1);
        e1r = issueRef(aRx, aRy, k - 1);
        e3c = e1c;
        e3r = e1r;
      end else if (b2b && k >= 10 && k <= 16) begin
        e1c = issueRef(bCx, bCy, k - 10);
        e1r = issueRef(bRx, bRy, k - 10);
      end
      if (k == 9) held1 = fullRef(aCx, aCy, aRx, aRy);
      if (b2b && k == 18) held1 = fullRef(bCx, bCy, bRx, bRy);
      if (k == 11) held3 = fullRef(aCx, aCy, aRx, aRy);
      checkOutput("cf1_issue", {cf1En, cf1Addr}, e1c);
      checkOutput("rf1_issue", {rf1En, rf1Addr}, e1r);
      checkOutput("cf3_issue", {cf3En, cf3Addr}, e3c);
      checkOutput("rf3_issue", {rf3En, rf3Addr}, e3r);
      checkOutput("busy1", busy1, (k <= 8) || (b2b && k >= 10 && k <= 17));
      checkOutput("done1", done1, (k == 9) || (b2b && k == 18));
      checkOutput("busy3", busy3, k <= 10);
      checkOutput("done3", done3, k == 11);
      checkOutput("result1", {cf1Oob, rf1Oob, cf1Pix, rf1Pix}, held1);
      checkOutput("result3", {cf3Oob, rf3Oob, cf3Pix, rf3Pix}, held3);
      req = (noisy && k >= 2 && k <= 8) || (b2b && k == 9);
      if (b2b && k == 9) begin
        cfX = bCx; cfY = bCy; rfX = bRx; rfY = bRy;
      end else begin
        cfX = noiseBus(); cfY = noiseBus(); rfX = noiseBus(); rfY = noiseBus();
      end
    end
    req = 1'b0;
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_ctl1"}, {busy1, done1, cf1En, rf1En, cf1Addr, rf1Addr}, '0);
    checkOutput({tag, "_ctl3"}, {busy3, done3, cf3En, rf3En, cf3Addr, rf3Addr}, '0);
    checkOutput({tag, "_out1"}, {cf1Oob, rf1Oob, cf1Pix, rf1Pix}, '0);
    checkOutput({tag, "_out3"}, {cf3Oob, rf3Oob, cf3Pix, rf3Pix}, '0);
  endtask

  // Start a fetch, assert rst in cycle 5, expect everything cleared in cycle 6.
  task automatic resetMidFetch();
    cfX = randBus(); cfY = randBus(); rfX = randBus(); rfY = randBus();
    req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkCleared("midReset");
    rst = 1'b0;
    held1 = '0;
    held3 = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [48:0] ax, ay, bx, by, cx, cy, dx, dy;
    rst = 1'b1;
    req = 1'b0;
    cfX = '0; cfY = '0; rfX = '0; rfY = '0;
    held1 = '0;
    held3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkCleared("reset");
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    ax = {7{7'd8}};
    applyStimulus(ax, ax, ax, ax, ax, ax, ax, ax, 1'b0, 1'b0);
    checkOutput("eight_cf1", cf1Pix, {7{8'd8}});
    checkOutput("eight_rf1", rf1Pix, {7{8'd11}});
    checkOutput("eight_cf3", cf3Pix, {7{8'd8}});
    checkOutput("eight_rf3", rf3Pix, {7{8'd11}});

    for (int s = 0; s < 7; s++) ax[7*s +: 7] = 7'(s);
    applyStimulus(ax, ax, ax, ax, ax, ax, ax, ax, 1'b0, 1'b0);
    checkOutput("diag_cf_slot3", cf1Pix[31:24], 8'd35);
    checkOutput("diag_cf_slot6", cf1Pix[55:48], 8'd70);
    checkOutput("diag_rf_slot6", rf1Pix[55:48], 8'd73);

    for (int s = 0; s < 7; s++) begin
      ax[7*s +: 7] = 7'(10 + s);
      ay[7*s +: 7] = 7'(20 + s);
      bx[7*s +: 7] = 7'(30 + s);
      by[7*s +: 7] = 7'(40 + s);
    end
    ax[14 +: 7] = 7'd96;
    by[35 +: 7] = 7'd100;
    applyStimulus(ax, ay, bx, by, ax, ay, bx, by, 1'b0, 1'b0);
    checkOutput("oob_cf", cf1Oob, 7'b0000100);
    checkOutput("oob_rf", rf1Oob, 7'b0100000);
    checkOutput("oob_cf_byte", cf1Pix[23:16], 8'd0);
    checkOutput("oob_rf_byte", rf1Pix[47:40], 8'd0);

    ax = randBus(); ay = randBus(); bx = randBus(); by = randBus();
    cx = randBus(); cy = randBus(); dx = randBus(); dy = randBus();
    applyStimulus(ax, ay, bx, by, cx, cy, dx, dy, 1'b1, 1'b1);

    resetMidFetch();
    ax = randBus(); ay = randBus(); bx = randBus(); by = randBus();
    applyStimulus(ax, ay, bx, by, ax, ay, bx, by, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      ax = randBus(); ay = randBus(); bx = randBus(); by = randBus();
      cx = randBus(); cy = randBus(); dx = randBus(); dy = randBus();
      applyStimulus(ax, ay, bx, by, cx, cy, dx, dy,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/hex_pixel_fetch.md
Name: hex_pixel_fetch

Overview:
- Upstream feeder for the hexagonal-search SAD stage.
- On a fetch request, latches the 7 hexagon coordinate pairs for the current frame and the 7 for the reference frame.
- Reads the corresponding pixels from two single-port synchronous frame memories (current, reference), one read per memory per cycle.
- Returns all 14 pixel values together with a one-cycle done pulse and per-slot out-of-frame flags.

Parameters:
- FRAME_W, 96, pixels per row (y range 0..FRAME_W-1)
- FRAME_H, 96, rows per frame (x range 0..FRAME_H-1)
- ADDR_W, 14, memory address width; must satisfy 2^ADDR_W >= FRAME_W*FRAME_H
- READ_LATENCY, 1, memory cycles from en/addr to valid rdata; legal range 1..3

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req  in  1  fetch request pulse; accepted only when busy==0
- cf_x_bus  in  49  current-frame x coords; slot s occupies bits [7s+6:7s]
- cf_y_bus  in  49  current-frame y coords, same packing
- rf_x_bus  in  49  reference-frame x coords, same packing
- rf_y_bus  in  49  reference-frame y coords, same packing
- cf_mem_en  out  1  current-frame memory read enable
- cf_mem_addr  out  ADDR_W  current-frame read address
- cf_mem_rdata  in  8  current-frame read data
- rf_mem_en  out  1  reference-frame memory read enable
- rf_mem_addr  out  ADDR_W  reference-frame read address
- rf_mem_rdata  in  8  reference-frame read data
- cf_pix_bus  out  56  current-frame pixels; slot s at [8s+7:8s]
- rf_pix_bus  out  56  reference-frame pixels, same packing
- cf_oob  out  7  bit s set if current slot s was out of frame
- rf_oob  out  7  bit s set if reference slot s was out of frame
- busy  out  1  fetch in progress
- done  out  1  one-cycle pulse; result buses valid

Behaviour:
- Reset (synchronous, any state, including mid-fetch): state returns to IDLE and all outputs go to 0. In-flight reads are discarded, and the staging registers and slot counter are cleared.
- States:
  - IDLE: req=1 latches all four coordinate buses and moves to ISSUE with slot=0.
  - ISSUE: one slot per cycle, slot 0..6 in order. At slot 6, moves to DRAIN.
  - DRAIN: holds for READ_LATENCY cycles, then moves to DONE.
  - DONE: lasts one cycle, with done=1. If req=1 in this cycle it is accepted and the next state is ISSUE; otherwise the next state is IDLE.
- busy=1 in ISSUE and DRAIN, 0 in IDLE and DONE. req is ignored while busy=1, and the latched coordinates do not change.
- Address: addr = x*FRAME_W + y, computed without truncation, then driven on ADDR_W bits.
- Out-of-frame slot: a slot is out of frame when x >= FRAME_H or y >= FRAME_W, evaluated per frame independently.
  - The memory enable for that slot's cycle is 0 and the address is driven as 0.
  - The staged pixel is 0 and the oob bit is set.
- In-frame slot: mem_en=1 during its ISSUE cycle. rdata is captured into staging slot s exactly READ_LATENCY cycles later, using a READ_LATENCY-deep delayed valid/slot pipeline.
- mem_en=0 and addr=0 in IDLE, DRAIN and DONE.
- Output update: on the edge entering DONE, staging is copied to cf_pix_bus, rf_pix_bus, cf_oob and rf_oob.
  - These outputs hold until the next entry into DONE.
  - They never change during busy.
- Latency: req sampled in cycle 0; slot s is issued in cycle 1+s; done=1 in cycle 8+READ_LATENCY. With the default this is cycle 9.
- Back-to-back: req in the DONE cycle gives the next done 8+READ_LATENCY cycles later. This is a period of 8+READ_LATENCY cycles with no idle gap.
- Coordinates are 7-bit unsigned. There is no wrap-around, so coordinates 96..127 are out of frame.

Test Plan:
- Memory model for all scenarios: cf[a]=a mod 256 and rf[a]=(a+3) mod 256, READ_LATENCY=1.
- All 7 slots at (x=8,y=8) in both frames, req pulse in cycle 0:
  - addr=776 issued in cycles 1..7.
  - done only in cycle 9.
  - every cf byte = 8, every rf byte = 11, oob = 0.
- Slot s at (x=s,y=s): cf slot s = (97s) mod 256, giving slot 3 = 35 and slot 6 = 70. rf slot s is that value +3 mod 256.
- cf slot 2 at x=96, rf slot 5 at y=100, all other slots in frame:
  - cf_mem_en=0 in cycle 3 and rf_mem_en=0 in cycle 6.
  - cf_oob=0000100 and rf_oob=0100000; the corresponding pixel bytes are 0.
- req asserted again in cycles 2..8 → ignored, and done occurs once. Then req in the DONE cycle 9 → new coordinates are issued from cycle 10, and the next done is in cycle 18.
- rst=1 in cycle 5 of a fetch → the next cycle shows busy=0, done=0, all buses 0 and mem_en=0. A following req completes normally 9 cycles later.
- READ_LATENCY=3 with the first scenario's stimulus → done in cycle 11 and identical pixel values.
